// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble/freeze control for the five-stage pipe, beside ID.
// Optional perf counters under `HAZARD_CTRL_PERF_EN`. Revision: 1.0
`default_nettype none

module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        dmem_busy_i,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        freeze_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

  // The first stall cycle is spent in RUN, so the counter covers the rest minus one.
  localparam logic [1:0] STALL_RELOAD =
    (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ret_ls_q, ret_ls_d;
  logic       pend_q, pend_d;
  logic       lu;
  logic [1:0] eff_state;

  always_comb begin
    lu = ex_memread_i && (ex_rd_i != 5'd0) &&
         ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    // Leaving MEM_WAIT resumes the saved state's evaluation in the same cycle.
    eff_state = (state_q == ST_MEM_WAIT) ? (ret_ls_q ? ST_LOAD_STALL : ST_RUN) : state_q;

    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    freeze_o       = 1'b0;
    state_d        = eff_state;
    cnt_d          = cnt_q;
    ret_ls_d       = ret_ls_q;
    pend_d         = pend_q;

    if (dmem_busy_i) begin
      freeze_o     = 1'b1;
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
      state_d      = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        ret_ls_d = (state_q == ST_LOAD_STALL);
      end
      if (branch_taken_i) begin
        pend_d = 1'b1;
      end
    end else begin
      case (eff_state)
        ST_LOAD_STALL: begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_bubble_o = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          if (lu) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_d   = STALL_RELOAD;
              state_d = ST_LOAD_STALL;
            end
          end else if (branch_taken_i || pend_q) begin
            if_id_flush_o = 1'b1;
            pend_d        = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      ret_ls_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ret_ls_q <= ret_ls_d;
      pend_q   <= pend_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (pc_hold_o) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush_o) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three instances (LOAD_STALL_CYCLES = 1, 2, 3) on shared inputs,
// checked against hand tables and a cycle-owed reference model. Revision: 1.0
`default_nettype none

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       ur = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0;

  logic [2:0]  pc_hold, if_hold, flush, bubble, freeze;
  logic [1:0]  st   [3];
  logic [31:0] scyc [3];
  logic [31:0] fcnt [3];

  int nvec = 0;
  int nerr = 0;

  // Reference model: stall cycles still owed, pending flush, previous cycle frozen.
  int          mrem  [3];
  bit          mpend [3];
  bit          mfz   [3];
  int unsigned mh    [3];
  int unsigned mf    [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    hazard_ctrl #(.LOAD_STALL_CYCLES(k + 1)) u_dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .id_rs_i        (rs),
      .id_rt_i        (rt),
      .id_uses_rt_i   (ur),
      .ex_memread_i   (mr),
      .ex_rd_i        (rd),
      .branch_taken_i (br),
      .dmem_busy_i    (busy),
      .pc_hold_o      (pc_hold[k]),
      .if_id_hold_o   (if_hold[k]),
      .if_id_flush_o  (flush[k]),
      .id_ex_bubble_o (bubble[k]),
      .freeze_o       (freeze[k]),
      .state_o        (st[k]),
      .stall_cycles_o (scyc[k]),
      .flush_count_o  (fcnt[k])
    );
  end

  typedef struct {
    logic       busy, mr;
    logic [4:0] rd, rs, rt;
    logic       ur, br;
    logic       hold, bub, fl, frz;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic b, input logic m, input logic [4:0] d,
                              input logic [4:0] s, input logic [4:0] t, input logic u,
                              input logic r, input logic h, input logic bb,
                              input logic f, input logic z, input logic [1:0] q);
    vec_t v;
    v.busy = b; v.mr = m; v.rd = d; v.rs = s; v.rt = t; v.ur = u; v.br = r;
    v.hold = h; v.bub = bb; v.fl = f; v.frz = z; v.st = q;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    busy = 0; mr = 0; rd = 0; rs = 0; rt = 0; ur = 0; br = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mrem[k] = 0; mpend[k] = 0; mfz[k] = 0; mh[k] = 0; mf[k] = 0;
    end
  endtask

  // Evaluate the model for the current inputs, optionally compare, then advance one clock.
  task automatic cycle(input bit do_chk);
    logic       lu, eh, eb, ef, ez;
    logic [1:0] es;
    #1;
    lu = mr && (rd != 0) && ((rd == rs) || (ur && (rd == rt)));
    for (int k = 0; k < 3; k++) begin
      es = mfz[k] ? 2'd2 : ((mrem[k] > 0) ? 2'd1 : 2'd0);
      eh = 0; eb = 0; ef = 0; ez = 0;
      if (busy) begin
        eh = 1; ez = 1;
        if (br) mpend[k] = 1;
        mfz[k] = 1;
      end else begin
        mfz[k] = 0;
        if (mrem[k] > 0) begin
          eh = 1; eb = 1; mrem[k]--;
        end else if (lu) begin
          eh = 1; eb = 1; mrem[k] = k;
        end else if (br || mpend[k]) begin
          ef = 1; mpend[k] = 0;
        end
      end
      mh[k] += 32'(eh);
      mf[k] += 32'(ef);
      if (do_chk) begin
        chk($sformatf("n%0d pc_hold", k + 1), 32'(pc_hold[k]), 32'(eh));
        chk($sformatf("n%0d if_id_hold", k + 1), 32'(if_hold[k]), 32'(eh));
        chk($sformatf("n%0d bubble", k + 1), 32'(bubble[k]), 32'(eb));
        chk($sformatf("n%0d flush", k + 1), 32'(flush[k]), 32'(ef));
        chk($sformatf("n%0d freeze", k + 1), 32'(freeze[k]), 32'(ez));
        chk($sformatf("n%0d state", k + 1), 32'(st[k]), 32'(es));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    for (int k = 0; k < 3; k++) begin
`ifdef HAZARD_CTRL_PERF_EN
      chk($sformatf("%s n%0d stall_cycles", tag, k + 1), scyc[k], mh[k]);
      chk($sformatf("%s n%0d flush_count", tag, k + 1), fcnt[k], mf[k]);
`else
      chk($sformatf("%s n%0d stall_cycles", tag, k + 1), scyc[k], 32'd0);
      chk($sformatf("%s n%0d flush_count", tag, k + 1), fcnt[k], 32'd0);
`endif
    end
  endtask

  initial begin
    //           busy mr rd rs rt ur br | hold bub fl frz st   (LOAD_STALL_CYCLES=3)
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[1]  = mk(0, 1, 5, 5, 0, 0, 0,  1, 1, 0, 0, 2'd0);
    tbl[2]  = mk(0, 0, 5, 5, 0, 0, 0,  1, 1, 0, 0, 2'd1);
    tbl[3]  = mk(0, 0, 5, 5, 0, 0, 0,  1, 1, 0, 0, 2'd1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[6]  = mk(0, 1, 7, 3, 7, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[7]  = mk(0, 1, 7, 3, 7, 1, 0,  1, 1, 0, 0, 2'd0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2'd1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'd2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'd1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 2'd0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2'd2);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2'd2);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2'd2);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2'd2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
    tbl[18] = mk(0, 1, 4, 4, 0, 0, 1,  1, 1, 0, 0, 2'd0);
    tbl[19] = mk(0, 0, 4, 4, 0, 0, 1,  1, 1, 0, 0, 2'd1);
    tbl[20] = mk(0, 0, 4, 4, 0, 0, 1,  1, 1, 0, 0, 2'd1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 2'd0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);

    model_reset();
    idle_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset n%0d state", k + 1), 32'(st[k]), 32'd0);
      chk($sformatf("reset n%0d controls", k + 1),
          32'({pc_hold[k], if_hold[k], flush[k], bubble[k], freeze[k]}), 32'd0);
    end
    chk_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      busy = tbl[i].busy; mr = tbl[i].mr; rd = tbl[i].rd; rs = tbl[i].rs;
      rt = tbl[i].rt; ur = tbl[i].ur; br = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d pc_hold", i), 32'(pc_hold[2]), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d if_id_hold", i), 32'(if_hold[2]), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d bubble", i), 32'(bubble[2]), 32'(tbl[i].bub));
      chk($sformatf("tbl%0d flush", i), 32'(flush[2]), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d freeze", i), 32'(freeze[2]), 32'(tbl[i].frz));
      chk($sformatf("tbl%0d state", i), 32'(st[2]), 32'(tbl[i].st));
      cycle(0);
    end
`ifdef HAZARD_CTRL_PERF_EN
    chk("tbl stall_cycles", scyc[2], 32'd14);
    chk("tbl flush_count", fcnt[2], 32'd2);
`else
    chk("tbl stall_cycles", scyc[2], 32'd0);
    chk("tbl flush_count", fcnt[2], 32'd0);
`endif

    // Single-cycle load-use stall on the LOAD_STALL_CYCLES=1 instance.
    idle_inputs(); mr = 1; rd = 5; rs = 5;
    #1;
    chk("n1 lu pc_hold", 32'(pc_hold[0]), 32'd1);
    chk("n1 lu bubble", 32'(bubble[0]), 32'd1);
    chk("n1 lu state", 32'(st[0]), 32'd0);
    cycle(0);
    mr = 0;
    #1;
    chk("n1 after pc_hold", 32'(pc_hold[0]), 32'd0);
    chk("n1 after state", 32'(st[0]), 32'd0);
    cycle(0);
    idle_inputs();
    repeat (3) cycle(1);

    // Asynchronous reset while the 3-cycle instance sits in LOAD_STALL.
    mr = 1; rd = 6; rs = 6;
    cycle(1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("async rst n3 state", 32'(st[2]), 32'd0);
    chk("async rst n3 controls",
        32'({pc_hold[2], if_hold[2], flush[2], bubble[2], freeze[2]}), 32'd0);
    model_reset();
    chk_counters("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A flush pended during a freeze must not survive reset.
    busy = 1; br = 1;
    cycle(1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle(1);

    repeat (800) begin
      busy = ($urandom_range(0, 4) == 0);
      mr   = $urandom_range(0, 1) == 1;
      rd   = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      ur   = $urandom_range(0, 1) == 1;
      br   = ($urandom_range(0, 3) == 0);
      cycle(1);
    end
    idle_inputs();
    repeat (4) cycle(1);
    chk_counters("random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. Generates the stall (hold) and flush controls for the PC register and the IF/ID pipeline register, and the bubble-insert control for ID/EX, from load-use dependencies, taken branches/jumps resolved in ID, and a multi-cycle data-memory busy signal. Sits beside the ID stage. Its outputs are Mealy-combinational so they act at the same clock edge the IF/ID register samples them.

## Interface

Parameters:
- LOAD_STALL_CYCLES, default 1: cycles IF/ID is held per load-use hazard; legal range 1..3.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- id_rs_i  in  5  source register rs of the instruction in ID
- id_rt_i  in  5  source register rt of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads rt
- ex_memread_i  in  1  the EX instruction is a load
- ex_rd_i  in  5  destination register of the EX instruction
- branch_taken_i  in  1  branch taken or jump, resolved in ID this cycle
- dmem_busy_i  in  1  data memory has not completed; the whole pipe must freeze
- pc_hold_o  out  1  PC keeps its value
- if_id_hold_o  out  1  to the IF/ID hazard (hold) input
- if_id_flush_o  out  1  to the IF/ID flush input
- id_ex_bubble_o  out  1  ID/EX loads a NOP
- freeze_o  out  1  ID/EX, EX/MEM and MEM/WB hold
- state_o  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
- stall_cycles_o  out  32  performance counter (see Configuration)
- flush_count_o  out  32  performance counter (see Configuration)

## Operation

- Load-use hit (lu): ex_memread_i && ex_rd_i != 0 && (ex_rd_i == id_rs_i || (id_uses_rt_i && ex_rd_i == id_rt_i)).
- Priority: freeze > load-use stall > flush.
- Freeze: dmem_busy_i=1 in any state gives freeze_o=pc_hold_o=if_id_hold_o=1, id_ex_bubble_o=0 and if_id_flush_o=0. Next state is MEM_WAIT. The stall counter holds its value and the prior state is saved for return.
- MEM_WAIT: stays while dmem_busy_i=1. On dmem_busy_i=0 it returns to the saved state (RUN or LOAD_STALL) and normal evaluation resumes that same cycle.
- RUN, lu=1: pc_hold_o=if_id_hold_o=id_ex_bubble_o=1, if_id_flush_o=0. If LOAD_STALL_CYCLES>1, the counter loads LOAD_STALL_CYCLES-2 and the FSM enters LOAD_STALL. If LOAD_STALL_CYCLES=1, the FSM stays in RUN.
- LOAD_STALL: asserts the same three outputs regardless of lu. If the counter is 0, next state is RUN; otherwise the counter decrements.
- Flush: in RUN with lu=0 and no freeze, branch_taken_i=1 or pend_flush=1 gives if_id_flush_o=1. pend_flush clears at that edge.
- Branch during freeze: branch_taken_i=1 while dmem_busy_i=1 sets pend_flush. The flush is applied on the first non-frozen RUN cycle, even if branch_taken_i has dropped.
- Branch during a load-use stall: ignored, because its operands are invalid. It is re-evaluated after the stall.
- Reset mid-stall or mid-freeze: returns immediately to RUN with the counter and pend_flush cleared.

## Timing

- Reset values: state_o=0, counter=0, pend_flush=0, stall_cycles_o=0, flush_count_o=0. With all inputs at 0, every control output is 0.
- Control outputs are combinational from inputs and state, with zero latency. State, counter and pend_flush update on the rising edge of clk_i.
- A load-use stall lasts exactly LOAD_STALL_CYCLES unfrozen cycles. Frozen cycles extend it and are not counted.
- A flush lasts exactly one cycle per taken branch or pending flush.

## Configuration

- HAZARD_CTRL_PERF_EN defined:
  - stall_cycles_o increments on every cycle with pc_hold_o=1.
  - flush_count_o increments on every cycle with if_id_flush_o=1.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset.
- HAZARD_CTRL_PERF_EN undefined: the counter logic is removed. Both ports remain present and are constant 0.

## Test plan

- Load-use with LOAD_STALL_CYCLES=1 (ex_memread_i=1, ex_rd_i=5, id_rs_i=5): pc_hold_o, if_id_hold_o and id_ex_bubble_o are high for exactly 1 cycle, and state_o stays 0.
- Load-use with LOAD_STALL_CYCLES=3 and ex_memread_i dropped after the first cycle: holds and bubble are high for 3 cycles, state_o goes 1,1,0, and stall_cycles_o=3 (PERF_EN).
- Load to register 0, or a match only on rt with id_uses_rt_i=0: no stall.
- branch_taken_i pulse with dmem_busy_i=1 for 4 cycles: freeze_o is high for 4 cycles with no flush, then if_id_flush_o=1 on the 5th cycle, and flush_count_o=1.
- dmem_busy_i raised during the 2nd cycle of a 3-cycle load stall: freeze holds, state goes 2 then back to 1, and the remaining stall cycles complete afterwards.
- Reset asserted during LOAD_STALL: state_o=0, all controls 0, and counters 0 immediately, without waiting for a clock edge.
